// File: rtl/alu_regfile_dmem_pkg.sv
// rtl/alu_regfile_dmem_pkg.sv - shared widths and ALU opcodes for the execute/memory/writeback slice
package alu_regfile_dmem_pkg;

   localparam int DATA_W  = 16;
   localparam int REG_AW  = 3;
   localparam int DMEM_AW = 3;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_NOT = 3'b010;
   localparam logic [2:0] ALU_SHL = 3'b011;
   localparam logic [2:0] ALU_SHR = 3'b100;
   localparam logic [2:0] ALU_AND = 3'b101;
   localparam logic [2:0] ALU_OR  = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_regfile_dmem_alu16.sv
// rtl/alu_regfile_dmem_alu16.sv - combinational 8-operation ALU with zero flag
module alu16
   import alu_regfile_dmem_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [2:0]   alu_control,
   output logic [W-1:0] result,
   output logic         zero
);

   // Shift amount is always the low nibble of b, independent of W.
   logic [3:0] shamt;
   assign shamt = b[3:0];

   always_comb begin
      result = '0;
      case (alu_control)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_NOT: result = ~a;
         ALU_SHL: result = a << shamt;
         ALU_SHR: result = a >> shamt;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_SLT: result = {{(W-1){1'b0}}, (a < b)};
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_regfile_dmem.sv
// rtl/alu_regfile_dmem.sv - register file, ALU, data memory and write-back mux
module alu_regfile_dmem
   import alu_regfile_dmem_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] rd_addr_1,
   input  logic [REG_AW-1:0] rd_addr_2,
   input  logic [REG_AW-1:0] wr_dest,
   input  logic              reg_write_en,
   input  logic [DATA_W-1:0] imm,
   input  logic              alu_src,
   input  logic [2:0]        alu_control,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              mem_to_reg,
   output logic [DATA_W-1:0] rd_data_1,
   output logic [DATA_W-1:0] rd_data_2,
   output logic [DATA_W-1:0] alu_result,
   output logic              zero,
   output logic [DATA_W-1:0] mem_rd_data,
   output logic [DATA_W-1:0] wb_data
);

   localparam int NREGS  = 1 << REG_AW;
   localparam int NWORDS = 1 << DMEM_AW;

   logic [DATA_W-1:0]  regs [NREGS];
   logic [DATA_W-1:0]  mem  [NWORDS];
   logic [DATA_W-1:0]  operand_b;
   logic [DMEM_AW-1:0] mem_addr;

   assign rd_data_1 = regs[rd_addr_1];
   assign rd_data_2 = regs[rd_addr_2];
   assign operand_b = alu_src ? imm : rd_data_2;

   alu16 #(.W(DATA_W)) u_alu (
      .a           (rd_data_1),
      .b           (operand_b),
      .alu_control (alu_control),
      .result      (alu_result),
      .zero        (zero)
   );

   // Upper address bits are dropped so accesses wrap around the small memory.
   assign mem_addr    = alu_result[DMEM_AW-1:0];
   assign mem_rd_data = mem_read ? mem[mem_addr] : '0;
   assign wb_data     = mem_to_reg ? mem_rd_data : alu_result;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (reg_write_en) begin
         regs[wr_dest] <= wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NWORDS; i++) mem[i] <= '0;
      end else if (mem_write) begin
         mem[mem_addr] <= rd_data_2;
      end
   end

endmodule

// File: tb/tb_alu_regfile_dmem.sv
// tb/tb_alu_regfile_dmem.sv - directed self-checking bench for alu_regfile_dmem
module tb_alu_regfile_dmem;
   import alu_regfile_dmem_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic [REG_AW-1:0] rd_addr_1, rd_addr_2, wr_dest;
   logic              reg_write_en;
   logic [DATA_W-1:0] imm;
   logic              alu_src;
   logic [2:0]        alu_control;
   logic              mem_read, mem_write, mem_to_reg;
   logic [DATA_W-1:0] rd_data_1, rd_data_2, alu_result, mem_rd_data, wb_data;
   logic              zero;

   int checks = 0;
   int passed = 0;

   logic [DATA_W-1:0] sweep_exp [8];

   alu_regfile_dmem dut (
      .clk          (clk),
      .reset        (reset),
      .rd_addr_1    (rd_addr_1),
      .rd_addr_2    (rd_addr_2),
      .wr_dest      (wr_dest),
      .reg_write_en (reg_write_en),
      .imm          (imm),
      .alu_src      (alu_src),
      .alu_control  (alu_control),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_to_reg   (mem_to_reg),
      .rd_data_1    (rd_data_1),
      .rd_data_2    (rd_data_2),
      .alu_result   (alu_result),
      .zero         (zero),
      .mem_rd_data  (mem_rd_data),
      .wb_data      (wb_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Load a register from imm via r0 + imm (r0 is 0 throughout the sequence).
   task automatic load_imm(input logic [REG_AW-1:0] dst, input logic [DATA_W-1:0] val);
      rd_addr_1 = 0; alu_src = 1'b1; imm = val; alu_control = ALU_ADD;
      mem_to_reg = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      wr_dest = dst; reg_write_en = 1'b1;
      tick();
      reg_write_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1; rd_addr_1 = 0; rd_addr_2 = 0; wr_dest = 0; reg_write_en = 1'b0;
      imm = '0; alu_src = 1'b0; alu_control = ALU_ADD;
      mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      check("rst_rd1", rd_data_1, 16'h0000);
      check("rst_rd2", rd_data_2, 16'h0000);
      check("rst_alu", alu_result, 16'h0000);
      check("rst_zero", {15'd0, zero}, 16'h0001);
      check("rst_mrd", mem_rd_data, 16'h0000);
      check("rst_wb", wb_data, 16'h0000);

      // Immediate load r1 = 5
      rd_addr_1 = 0; alu_src = 1'b1; imm = 16'd5; alu_control = ALU_ADD;
      wr_dest = 1; reg_write_en = 1'b1;
      #1 check("li_wb", wb_data, 16'h0005);
      tick();
      reg_write_en = 1'b0; rd_addr_1 = 1;
      #1 check("li_r1", rd_data_1, 16'h0005);

      // ALU sweep
      load_imm(1, 16'h00F0);
      load_imm(2, 16'h0003);
      sweep_exp[0] = 16'h00F3; sweep_exp[1] = 16'h00ED;
      sweep_exp[2] = 16'hFF0F; sweep_exp[3] = 16'h0780;
      sweep_exp[4] = 16'h001E; sweep_exp[5] = 16'h0000;
      sweep_exp[6] = 16'h00F3; sweep_exp[7] = 16'h0000;
      rd_addr_1 = 1; rd_addr_2 = 2; alu_src = 1'b0;
      for (int op = 0; op < 8; op++) begin
         alu_control = op[2:0];
         #1 check($sformatf("sweep_op%0d", op), alu_result, sweep_exp[op]);
      end
      alu_control = ALU_AND;
      #1 check("and_zero", {15'd0, zero}, 16'h0001);
      alu_control = ALU_ADD;
      #1 check("add_nonzero", {15'd0, zero}, 16'h0000);
      rd_addr_1 = 2; rd_addr_2 = 1; alu_control = ALU_SLT;
      #1 check("slt_swap", alu_result, 16'h0001);
      rd_addr_1 = 1; rd_addr_2 = 1; alu_control = ALU_SUB;
      #1 check("sub_eq", alu_result, 16'h0000);
      check("sub_eq_zero", {15'd0, zero}, 16'h0001);

      // Store r2 = 0x1234 at address 2, then load into r3
      load_imm(2, 16'h1234);
      rd_addr_1 = 0; rd_addr_2 = 2; alu_src = 1'b1; imm = 16'd2; alu_control = ALU_ADD;
      mem_write = 1'b1;
      #1 check("st_addr", alu_result, 16'h0002);
      tick();
      mem_write = 1'b0; mem_read = 1'b1; mem_to_reg = 1'b1; wr_dest = 3; reg_write_en = 1'b1;
      #1 check("ld_mrd", mem_rd_data, 16'h1234);
      check("ld_wb", wb_data, 16'h1234);
      tick();
      reg_write_en = 1'b0; rd_addr_1 = 3;
      #1 check("ld_r3", rd_data_1, 16'h1234);
      rd_addr_1 = 0; mem_read = 1'b0;
      #1 check("noread_mrd", mem_rd_data, 16'h0000);
      check("noread_wb", wb_data, 16'h0000);

      // Address wrap: store at 10 lands at word 2
      load_imm(5, 16'h5555);
      rd_addr_1 = 0; rd_addr_2 = 5; alu_src = 1'b1; imm = 16'd10; alu_control = ALU_ADD;
      mem_write = 1'b1;
      tick();
      mem_write = 1'b0; mem_read = 1'b1; imm = 16'd2;
      #1 check("wrap_rd2", mem_rd_data, 16'h5555);
      imm = 16'd10;
      #1 check("wrap_rd10", mem_rd_data, 16'h5555);

      // Register read-during-write
      mem_read = 1'b0; mem_to_reg = 1'b0;
      rd_addr_1 = 0; rd_addr_2 = 4; imm = 16'h00AA; wr_dest = 4; reg_write_en = 1'b1;
      #1 check("rdw_reg_old", rd_data_2, 16'h0000);
      tick();
      reg_write_en = 1'b0;
      #1 check("rdw_reg_new", rd_data_2, 16'h00AA);

      // Memory read-during-write at address 2
      imm = 16'd2; mem_write = 1'b1; mem_read = 1'b1;
      #1 check("rdw_mem_old", mem_rd_data, 16'h5555);
      tick();
      mem_write = 1'b0;
      #1 check("rdw_mem_new", mem_rd_data, 16'h00AA);

      // Reset with writes pending discards them and clears everything
      rd_addr_1 = 0; rd_addr_2 = 4; imm = 16'h0077; wr_dest = 6;
      reg_write_en = 1'b1; mem_write = 1'b1; mem_read = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0; reg_write_en = 1'b0; mem_write = 1'b0;
      rd_addr_1 = 6; rd_addr_2 = 4;
      #1 check("mrst_r6", rd_data_1, 16'h0000);
      check("mrst_r4", rd_data_2, 16'h0000);
      rd_addr_1 = 1;
      #1 check("mrst_r1", rd_data_1, 16'h0000);
      rd_addr_1 = 0; imm = 16'd2; mem_read = 1'b1;
      #1 check("mrst_mem2", mem_rd_data, 16'h0000);
      imm = 16'd7;
      #1 check("mrst_mem7", mem_rd_data, 16'h0000);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/alu_regfile_dmem.md
Name: alu_regfile_dmem

Overview:
- Execute/memory/writeback slice of the 16-bit RISC datapath.
- Contains:
  - an 8-entry x 16-bit register file with two read ports and one write port;
  - a 16-bit ALU with 8 operations and a zero flag;
  - a small word-addressed data memory;
  - the write-back mux between the ALU result and memory load data.
- Sits between instruction decode (supplies register addresses, immediate and control strobes) and the PC/branch logic (consumes the zero flag).

Parameters:
- DATA_W, 16, datapath word width.
- REG_AW, 3, register address width (2^REG_AW registers).
- DMEM_AW, 3, data memory word-address width (2^DMEM_AW words).

Ports:
- clk  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high; clears all registers and all memory words.
- rd_addr_1  in  REG_AW  read port 1 address (ALU operand a).
- rd_addr_2  in  REG_AW  read port 2 address (operand b / store data).
- wr_dest  in  REG_AW  write-back destination register.
- reg_write_en  in  1  register write enable.
- imm  in  DATA_W  sign-extended immediate.
- alu_src  in  1  1 = operand b is imm, 0 = operand b is rd_data_2.
- alu_control  in  3  ALU operation select.
- mem_read  in  1  data memory read enable.
- mem_write  in  1  data memory write enable.
- mem_to_reg  in  1  1 = write back load data, 0 = write back ALU result.
- rd_data_1  out  DATA_W  register read port 1 data.
- rd_data_2  out  DATA_W  register read port 2 data.
- alu_result  out  DATA_W  ALU result; also the memory address.
- zero  out  1  high when alu_result == 0.
- mem_rd_data  out  DATA_W  memory load data.
- wb_data  out  DATA_W  value presented to the register write port.

Behaviour:
- Register file:
  - Reads are combinational (rd_data_x = reg[rd_addr_x]).
  - Writes: wb_data is written to reg[wr_dest] on the rising clk edge when reg_write_en=1 and reset=0.
  - All 8 registers are writable, including r0; none is hardwired.
  - A read in the same cycle as a write to the same address returns the old value; the new value is visible after the edge.
- ALU: a = rd_data_1, b = alu_src ? imm : rd_data_2. Purely combinational, results modulo 2^DATA_W.
  - 000: a+b
  - 001: a-b
  - 010: ~a
  - 011: a << b[3:0]
  - 100: a >> b[3:0] (logical)
  - 101: a & b
  - 110: a | b
  - 111: (a < b unsigned) ? 1 : 0
  - zero = (alu_result == 0).
- Data memory:
  - Word address = alu_result[DMEM_AW-1:0]; upper bits are ignored, so addresses wrap.
  - Write: rd_data_2 is stored on the rising edge when mem_write=1 and reset=0.
  - Read: combinational. mem_rd_data = mem[addr] when mem_read=1, else 0.
  - A read and a write to the same address in one cycle returns the old data until the edge.
- Write-back: wb_data = mem_to_reg ? mem_rd_data : alu_result.
- Reset:
  - Synchronous: on a clk edge with reset=1, all registers and all memory words become 0, and any write in that cycle is discarded.
  - After reset, with addresses 0 and no immediate, every output reads 0 and zero=1.
  - Reset asserted mid-sequence behaves identically.
- Latency: all outputs are combinational from inputs and current state; state updates take exactly one edge.
- No handshake is needed; every strobe is sampled on every edge.

Decomposition:
- Shared package holds:
  - DATA_W, REG_AW, DMEM_AW defaults;
  - the ALU opcode constants ALU_ADD=3'b000, ALU_SUB, ALU_NOT, ALU_SHL, ALU_SHR, ALU_AND, ALU_OR, ALU_SLT.
- One natural sub-module: alu16 (combinational ALU with zero flag).
- The register file and memory are inline arrays in the top.

Test Plan:
- Reset then immediate loads:
  - Assert reset one cycle; all rd_data read 0 and zero=1.
  - Then imm=5, alu_src=1, alu_control=ADD, rd_addr_1=0, wr_dest=1, reg_write_en=1; after the edge reg1=5.
- ALU sweep with reg1=0x00F0, reg2=0x0003:
  - ADD=0x00F3, SUB=0x00ED, NOT=0xFF0F, SHL=0x0780, SHR=0x001E, AND=0x0000 (zero=1), OR=0x00F3, SLT=0.
  - Swapping operands gives SLT=1.
  - SUB with equal operands gives zero=1.
- Store/load:
  - Store reg2=0x1234 at addr reg0+imm=2 with mem_write=1.
  - Next cycle, with mem_read=1 and mem_to_reg=1, write to reg3; reg3=0x1234.
  - With mem_read=0, mem_rd_data=0.
- Address wrap: a store to address 10 (DMEM_AW=3) then reads back at address 2.
- Read-during-write hazard: writing 0x00AA to reg4 while reading reg4 shows the old value that cycle and 0x00AA after the edge. The same check applies to memory.
- Reset mid-operation: reset asserted together with reg_write_en and mem_write discards the writes; registers and memory read 0 afterwards.
